// File: rtl/line_buffer_pkg.sv
// line_buffer_pkg: shared types and constants for the rotating line buffer sequencer.
package line_buffer_pkg;
    localparam int KERNEL_SIZE = 3;
    localparam int NUM_BANKS   = KERNEL_SIZE + 1;
    localparam int BANK_W      = $clog2(NUM_BANKS);
    localparam int HCOUNT_W    = 11;
    localparam int VCOUNT_W    = 10;

    typedef enum logic [1:0] {IDLE, PRIME, STREAM} lb_seq_state_t;

    function automatic logic [BANK_W-1:0] bank_inc(input logic [BANK_W-1:0] b);
        return b == BANK_W'(NUM_BANKS - 1) ? '0 : b + 1'b1;
    endfunction
endpackage

// File: rtl/line_buffer_sequencer_sync_checker.sv
// lb_sync_checker: tracks the next expected hcount and flags out-of-order pixels (sticky error).
module lb_sync_checker
    import line_buffer_pkg::*;
#(
    parameter int HRES = 1280
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    input  logic                i_active,
    input  logic                i_start,
    input  logic [HCOUNT_W-1:0] i_hcount,
    output logic                o_mismatch,
    output logic                o_sync_err
);
    logic [HCOUNT_W-1:0] r_exp_h;
    logic                r_err;

    assign o_mismatch = i_valid && i_active && i_hcount != r_exp_h;
    assign o_sync_err = r_err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_exp_h <= '0;
            r_err   <= 1'b0;
        end else if (o_mismatch) begin
            r_err <= 1'b1;
        end else if (i_valid && (i_active || i_start)) begin
            r_exp_h <= i_hcount == HCOUNT_W'(HRES - 1) ? '0 : i_hcount + 1'b1;
        end
    end
endmodule

// File: rtl/line_buffer_sequencer.sv
// line_buffer_sequencer: bank rotation, priming FSM and kernel-valid alignment for the 3x3 line buffer.
// Optional stream-order checking is enabled with `LB_SEQ_SYNC_CHECK_EN.
module line_buffer_sequencer
    import line_buffer_pkg::*;
#(
    parameter int HRES       = 1280,
    parameter int VRES       = 720,
    parameter int RD_LATENCY = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [HCOUNT_W-1:0]  hcount_in,
    input  logic [VCOUNT_W-1:0]  vcount_in,
    input  logic                 data_valid_in,
    output logic [NUM_BANKS-1:0] wr_en_out,
    output logic [BANK_W-1:0]    rd_oldest_out,
    output logic                 kernel_valid_out,
    output logic [HCOUNT_W-1:0]  center_hcount_out,
    output logic [VCOUNT_W-1:0]  center_vcount_out,
    output logic                 primed_out,
    output logic                 frame_done_out,
    output logic                 sync_err_out
);
    localparam int ROWS_W = $clog2(KERNEL_SIZE + 1);
    localparam int CH_W   = RD_LATENCY * HCOUNT_W;
    localparam int CV_W   = RD_LATENCY * VCOUNT_W;

    lb_seq_state_t                          r_state, w_state_nxt;
    logic [BANK_W-1:0]                      r_bank, r_rd_oldest, w_bank_nxt;
    logic [ROWS_W-1:0]                      r_rows, w_rows_nxt;
    logic                                   r_frame_done;
    logic                                   w_start, w_active, w_err, w_write;
    logic                                   w_line_end, w_frame_end, w_kv_in;
    logic [RD_LATENCY-1:0]                  r_kv;
    logic [RD_LATENCY-1:0][HCOUNT_W-1:0]    r_ch;
    logic [RD_LATENCY-1:0][VCOUNT_W-1:0]    r_cv;

    assign w_start     = data_valid_in && hcount_in == '0 && vcount_in == '0;
    assign w_active    = r_state != IDLE;
    assign w_write     = data_valid_in && (w_active || w_start) && !w_err && !rst_in;
    assign w_line_end  = w_write && w_active && hcount_in == HCOUNT_W'(HRES - 1);
    assign w_frame_end = w_line_end && vcount_in == VCOUNT_W'(VRES - 1);
    assign w_bank_nxt  = bank_inc(r_bank);
    assign w_kv_in     = w_write && r_state == STREAM;

    assign wr_en_out         = w_write ? NUM_BANKS'(1) << r_bank : '0;
    assign rd_oldest_out     = r_rd_oldest;
    assign primed_out        = r_rows == ROWS_W'(KERNEL_SIZE);
    assign frame_done_out    = r_frame_done;
    assign kernel_valid_out  = r_kv[RD_LATENCY-1];
    assign center_hcount_out = r_ch[RD_LATENCY-1];
    assign center_vcount_out = r_cv[RD_LATENCY-1];

`ifdef LB_SEQ_SYNC_CHECK_EN
    lb_sync_checker #(.HRES(HRES)) u_sync (
        .i_clk      (clk_in),
        .i_rst      (rst_in),
        .i_valid    (data_valid_in),
        .i_active   (w_active),
        .i_start    (w_start),
        .i_hcount   (hcount_in),
        .o_mismatch (w_err),
        .o_sync_err (sync_err_out)
    );
`else
    assign w_err        = 1'b0;
    assign sync_err_out = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_rows_nxt  = r_rows;
        if (w_err) begin
            w_state_nxt = IDLE;
            w_rows_nxt  = '0;
        end else if (r_state == IDLE) begin
            w_state_nxt = w_start ? PRIME : IDLE;
        end else if (w_frame_end) begin
            w_state_nxt = IDLE;
            w_rows_nxt  = '0;
        end else if (w_line_end) begin
            w_rows_nxt  = r_rows == ROWS_W'(KERNEL_SIZE) ? r_rows : r_rows + 1'b1;
            w_state_nxt = w_rows_nxt == ROWS_W'(KERNEL_SIZE) ? STREAM : r_state;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state      <= IDLE;
            r_bank       <= '0;
            r_rd_oldest  <= '0;
            r_rows       <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rows       <= w_rows_nxt;
            r_frame_done <= w_frame_end;
            if (w_line_end) begin
                r_bank      <= w_bank_nxt;
                r_rd_oldest <= bank_inc(w_bank_nxt);
            end
        end
    end

    // Shift registers: newest sample enters at index 0, output taken from the top.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_kv <= '0;
            r_ch <= '0;
            r_cv <= '0;
        end else begin
            r_kv <= RD_LATENCY'({r_kv, w_kv_in});
            r_ch <= CH_W'({r_ch, hcount_in});
            r_cv <= CV_W'({r_cv, vcount_in - VCOUNT_W'(KERNEL_SIZE - 1)});
        end
    end
endmodule

// File: tb/tb_line_buffer_sequencer.sv
// tb_line_buffer_sequencer: randomized stream against a frame/line-level reference model with a kernel-output scoreboard.
module tb_line_buffer_sequencer;
    import line_buffer_pkg::*;

    localparam int HRES = 8;
    localparam int VRES = 6;
    localparam int RDL  = 2;
`ifdef LB_SEQ_SYNC_CHECK_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic                 clk = 1'b0, rst = 1'b0, dv = 1'b0;
    logic [HCOUNT_W-1:0]  hc = '0;
    logic [VCOUNT_W-1:0]  vc = '0;
    logic [NUM_BANKS-1:0] wr_en;
    logic [BANK_W-1:0]    rd_old;
    logic                 kv, primed, fdone, serr;
    logic [HCOUNT_W-1:0]  ch;
    logic [VCOUNT_W-1:0]  cv;

    line_buffer_sequencer #(.HRES(HRES), .VRES(VRES), .RD_LATENCY(RDL)) dut (
        .clk_in            (clk),
        .rst_in            (rst),
        .hcount_in         (hc),
        .vcount_in         (vc),
        .data_valid_in     (dv),
        .wr_en_out         (wr_en),
        .rd_oldest_out     (rd_old),
        .kernel_valid_out  (kv),
        .center_hcount_out (ch),
        .center_vcount_out (cv),
        .primed_out        (primed),
        .frame_done_out    (fdone),
        .sync_err_out      (serr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int due; int h; int v;} exp_t;
    exp_t q[$];
    int n_cmp = 0, n_bad = 0;

    // Reference model: frame/line bookkeeping in plain integers.
    bit m_active, m_fd, m_err;
    int m_bank, m_old, m_lines, m_exp;

    task automatic chk(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_fd = 0; m_err = 0;
        m_bank = 0; m_old = 0; m_lines = 0; m_exp = 0;
        q.delete();
    endtask

    task automatic step(input bit v, input int h, input int vv);
        bit start, mism, wr, streaming;
        @(negedge clk);
        dv = v; hc = HCOUNT_W'(h); vc = VCOUNT_W'(vv);
        #1;
        start     = v && h == 0 && vv == 0;
        mism      = SYNC && m_active && v && h != m_exp;
        wr        = v && (m_active || start) && !mism;
        streaming = m_active && m_lines == KERNEL_SIZE;
        chk("wr_en", int'(wr_en), wr ? (1 << m_bank) : 0);
        chk("rd_oldest", int'(rd_old), m_old);
        chk("primed", int'(primed), int'(streaming));
        chk("frame_done", int'(fdone), int'(m_fd));
        chk("sync_err", int'(serr), int'(m_err));
        if (wr && streaming) q.push_back('{cyc + RDL, h, vv - (KERNEL_SIZE - 1)});
        m_fd = 0;
        if (mism) begin
            m_err = 1; m_active = 0; m_lines = 0;
        end else if (wr) begin
            m_exp = (h + 1) % HRES;
            if (!m_active) m_active = 1;
            else if (h == HRES - 1) begin
                m_bank = (m_bank + 1) % NUM_BANKS;
                m_old  = (m_bank + 1) % NUM_BANKS;
                if (m_lines < KERNEL_SIZE) m_lines++;
                if (vv == VRES - 1) begin
                    m_fd = 1; m_active = 0; m_lines = 0;
                end
            end
        end
    endtask

    task automatic idle_step();
        step(1'b0, $urandom_range(0, HRES - 1), $urandom_range(0, VRES - 1));
    endtask

    task automatic reset_mid(input int h, input int vv);
        @(negedge clk);
        rst = 1; dv = 1; hc = HCOUNT_W'(h); vc = VCOUNT_W'(vv);
        #1;
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_kv", int'(kv), 0);
        chk("rst_center_h", int'(ch), 0);
        chk("rst_center_v", int'(cv), 0);
        chk("rst_rd_oldest", int'(rd_old), 0);
        chk("rst_primed", int'(primed), 0);
        chk("rst_frame_done", int'(fdone), 0);
        chk("rst_sync_err", int'(serr), 0);
        model_reset();
        @(negedge clk);
        rst = 0; dv = 0;
    endtask

    // skip_line drops hcount 4 on that line; stop_line aborts mid-line so a reset can follow.
    task automatic send_frame(input int v0, input int h0, input int skip_line, input int stop_line);
        for (int l = v0; l < VRES; l++) begin
            for (int x = (l == v0 ? h0 : 0); x < HRES; x++) begin
                if (l == stop_line && x == HRES / 2) return;
                if (l == skip_line && x == 4) continue;
                if (l == 4 && x == HRES / 2) repeat (3) idle_step();
                else if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) idle_step();
                step(1'b1, x, l);
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (kv) begin
                if (q.size() == 0) chk("kernel_valid_unexpected", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("kv_cycle", cyc, e.due);
                    chk("center_h", int'(ch), e.h);
                    chk("center_v", int'(cv), e.v);
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                chk("kernel_valid_missing", 0, 1);
            end
        end
    end

    initial begin
        model_reset();
        #1 rst = 1;
        reset_mid(0, 0);
        send_frame(2, 4, -1, -1);
        repeat (2) idle_step();
        send_frame(0, 0, -1, -1);
        send_frame(0, 0, -1, -1);
        repeat (3) idle_step();
        send_frame(0, 0, -1, 4);
        reset_mid(HRES / 2, 4);
        send_frame(0, 0, 3, -1);
        repeat (2) idle_step();
        send_frame(0, 0, -1, -1);
        repeat (6) idle_step();
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
